// File: rtl/lsu_ctrl.sv
// Load/store unit front-end: alignment/legality check, word-aligned memory request
// with byte mask, and sized sign/zero-extended load return. One transaction in flight.
module lsu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_op_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic [3:0]       mem_wmask_o,
  input  logic             mem_rsp_valid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             legal_c;
  logic             aligned_c;
  logic [3:0]       lane_wmask_c;
  logic [WIDTH-1:0] lane_wdata_c;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] load_ext_c;

  // Decode incoming request: legality, alignment and store byte-lane placement
  always_comb begin
    legal_c      = 1'b0;
    aligned_c    = 1'b1;
    lane_wmask_c = 4'b0000;
    lane_wdata_c = '0;
    if (req_we_i) begin
      legal_c = (req_op_i == 3'b000) || (req_op_i == 3'b001) || (req_op_i == 3'b010);
    end else begin
      legal_c = (req_op_i == 3'b000) || (req_op_i == 3'b001) || (req_op_i == 3'b010) ||
                (req_op_i == 3'b100) || (req_op_i == 3'b101);
    end
    if (req_op_i[1:0] == 2'b01) begin
      aligned_c = (req_addr_i[0] == 1'b0);
    end else if (req_op_i[1:0] == 2'b10) begin
      aligned_c = (req_addr_i[1:0] == 2'b00);
    end
    if (req_we_i) begin
      case (req_op_i)
        3'b000: begin
          lane_wmask_c = 4'b0001 << req_addr_i[1:0];
          lane_wdata_c = {4{req_wdata_i[7:0]}};
        end
        3'b001: begin
          lane_wmask_c = 4'b0011 << req_addr_i[1:0];
          lane_wdata_c = {2{req_wdata_i[15:0]}};
        end
        3'b010: begin
          lane_wmask_c = 4'b1111;
          lane_wdata_c = req_wdata_i;
        end
        default: begin
          lane_wmask_c = 4'b0000;
          lane_wdata_c = '0;
        end
      endcase
    end
  end

  // Extract and extend the addressed bytes of the returned word
  always_comb begin
    shifted_c  = mem_rdata_i >> {off_q, 3'b000};
    load_ext_c = '0;
    case (op_q)
      3'b000:  load_ext_c = {{(WIDTH-8){shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_ext_c = {{(WIDTH-8){1'b0}}, shifted_c[7:0]};
      3'b001:  load_ext_c = {{(WIDTH-16){shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_ext_c = {{(WIDTH-16){1'b0}}, shifted_c[15:0]};
      3'b010:  load_ext_c = shifted_c;
      default: load_ext_c = '0;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          off_d   = req_addr_i[1:0];
          rdata_d = '0;
          if (legal_c && aligned_c) begin
            we_d    = req_we_i;
            addr_d  = {req_addr_i[WIDTH-1:2], 2'b00};
            wdata_d = lane_wdata_c;
            wmask_d = lane_wmask_c;
            err_d   = 1'b0;
            state_d = S_REQ;
          end else begin
            we_d    = 1'b0;
            wmask_d = 4'b0000;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          rdata_d = we_q ? '0 : load_ext_c;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign mem_req_valid_o = (state_q == S_REQ);
  assign rsp_valid_o     = (state_q == S_RESP);
  assign mem_we_o        = we_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign rsp_rdata_o     = rdata_q;
  assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: vector table plus backpressure,
// spurious-response and mid-transaction reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rdata_i(mem_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        e_err;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int unsigned NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"},     32'(req_ready_o),     32'd1);
    chk({tag, " mem_req_valid"}, 32'(mem_req_valid_o), 32'd0);
    chk({tag, " mem_we"},        32'(mem_we_o),        32'd0);
    chk({tag, " mem_addr"},      mem_addr_o,           32'd0);
    chk({tag, " mem_wdata"},     mem_wdata_o,          32'd0);
    chk({tag, " mem_wmask"},     32'(mem_wmask_o),     32'd0);
    chk({tag, " rsp_valid"},     32'(rsp_valid_o),     32'd0);
    chk({tag, " rsp_rdata"},     rsp_rdata_o,          32'd0);
    chk({tag, " rsp_err"},       32'(rsp_err_o),       32'd0);
  endtask

  // Drive a request so that it is accepted on the next rising edge
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("pre-accept req_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_op_i    = op;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_wdata_i = 32'hDEAD_DEAD;
    req_addr_i  = 32'hFFFF_FFFF;
  endtask

  // Full transaction with a zero-wait memory; checks cycle-exact latency
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    issue(v.we, v.op, v.addr, v.wdata);
    if (v.e_err) begin
      chk({t, " err rsp_valid@N+1"},  32'(rsp_valid_o),     32'd1);
      chk({t, " err mem_req_valid"},  32'(mem_req_valid_o), 32'd0);
      chk({t, " err rsp_err"},        32'(rsp_err_o),       32'd1);
      chk({t, " err rsp_rdata"},      rsp_rdata_o,          32'd0);
    end else begin
      chk({t, " mem_req_valid@N+1"}, 32'(mem_req_valid_o), 32'd1);
      chk({t, " req_ready busy"},    32'(req_ready_o),     32'd0);
      chk({t, " mem_we"},            32'(mem_we_o),        32'(v.we));
      chk({t, " mem_addr"},          mem_addr_o,           v.e_addr);
      chk({t, " mem_wdata"},         mem_wdata_o,          v.e_wdata);
      chk({t, " mem_wmask"},         32'(mem_wmask_o),     32'(v.e_wmask));
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      chk({t, " wait mem_req_valid"}, 32'(mem_req_valid_o), 32'd0);
      chk({t, " wait rsp_valid"},     32'(rsp_valid_o),     32'd0);
      mem_rsp_valid_i = 1'b1;
      mem_rdata_i     = v.rdata;
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      mem_rdata_i     = 32'h5A5A_5A5A;
      chk({t, " rsp_valid@N+3"}, 32'(rsp_valid_o), 32'd1);
      chk({t, " rsp_rdata"},     rsp_rdata_o,       v.e_rdata);
      chk({t, " rsp_err"},       32'(rsp_err_o),    32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({t, " req_ready after rsp"}, 32'(req_ready_o), 32'd1);
    chk({t, " rsp_valid cleared"},   32'(rsp_valid_o), 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic e_err, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_wmask,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.e_err = e_err; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wmask = e_wmask;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    vecs[1]  = mk(0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080);
    vecs[2]  = mk(1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 32'h0);
    vecs[3]  = mk(0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    vecs[4]  = mk(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    vecs[5]  = mk(0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001);
    vecs[6]  = mk(0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_8001);
    vecs[7]  = mk(1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'h0, 0, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0);
    vecs[8]  = mk(1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 0, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 32'h0);
    vecs[9]  = mk(1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    vecs[10] = mk(0, 3'b001, 32'h8000_0003, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    vecs[11] = mk(0, 3'b000, 32'h8000_0000, 32'h0, 32'h0000_007F, 0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_007F);
    vecs[12] = mk(0, 3'b010, 32'h8000_000C, 32'h0, 32'h89AB_CDEF, 0, 32'h8000_000C, 32'h0, 4'b0000, 32'h89AB_CDEF);
    vecs[13] = mk(1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);

    rst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_op_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'h0;
    rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i], i);

    // Spurious response in IDLE must not start anything
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("idle spurious rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("idle spurious req_ready", 32'(req_ready_o), 32'd1);

    // Backpressure on the request with spurious responses, then late response, then held result
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk("bp mem_req_valid", 32'(mem_req_valid_o), 32'd1);
      chk("bp mem_addr",      mem_addr_o,           32'h8000_0010);
      chk("bp mem_wmask",     32'(mem_wmask_o),     32'd0);
      chk("bp mem_we",        32'(mem_we_o),        32'd0);
      chk("bp req_ready",     32'(req_ready_o),     32'd0);
      @(negedge clk);
    end
    mem_rsp_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    repeat (2) begin
      chk("bp wait rsp_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 32'h1122_3344;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = 32'hFFFF_0000;
    for (int c = 0; c < 3; c++) begin
      chk("bp rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp rsp_rdata", rsp_rdata_o,       32'h1122_3344);
      chk("bp rsp_err",   32'(rsp_err_o),    32'd0);
      chk("bp req_ready", 32'(req_ready_o),  32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("bp req_ready after", 32'(req_ready_o), 32'd1);

    // Asynchronous reset while a store sits in WAIT
    issue(1'b1, 3'b010, 32'h8000_0020, 32'hFFFF_FFFF);
    chk("rstwait mem_wdata pre", mem_wdata_o, 32'hFFFF_FFFF);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstwait");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    chk("rstwait no rsp", 32'(rsp_valid_o), 32'd0);
    run_vec(mk(0, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 32'h8000_0004, 32'h0,
               4'b0000, 32'h1234_5678), 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
